// File: rtl/config_chain_loader.sv
// Configuration chain loader: takes bytes over valid/ready and shifts them MSB-first
// onto the fabric config chain head, one strobe per bit, until CHAIN_LEN bits are shifted.
module config_chain_loader #(
    parameter  int CHAIN_LEN = 200,
    parameter  int SHIFT_DIV = 2,
    localparam int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [7:0]       s_data,
    input  logic             s_valid,
    output logic             s_ready,
    output logic             ccff_head,
    output logic             ccff_shift_en,
    output logic             cfg_done,
    output logic             busy,
    output logic             err,
    output logic [CNT_W-1:0] bit_count
);

    localparam int DIV_W = (SHIFT_DIV > 1) ? $clog2(SHIFT_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SHIFT_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CHAIN_LEN);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    state_t           state_q, state_d;
    logic [7:0]       byte_q, byte_d;
    logic [3:0]       left_q, left_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             head_q, head_d;
    logic             err_q, err_d;
    logic             strobe;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            byte_q  <= '0;
            left_q  <= '0;
            div_q   <= '0;
            cnt_q   <= '0;
            head_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            byte_q  <= byte_d;
            left_q  <= left_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            head_q  <= head_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        byte_d  = byte_q;
        left_d  = left_q;
        div_d   = div_q;
        cnt_d   = cnt_q;
        head_d  = head_q;
        err_d   = err_q;
        strobe  = 1'b0;
        s_ready = 1'b0;
        busy    = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                end
            end
            LOAD: begin
                busy = 1'b1;
                if (abort) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else begin
                    s_ready = 1'b1;
                    if (s_valid) begin
                        byte_d  = s_data;
                        left_d  = 4'd8;
                        div_d   = '0;
                        state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (abort) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else if (div_q == DIV_LAST) begin
                    strobe = 1'b1;
                    byte_d = {byte_q[6:0], 1'b0};
                    left_d = left_q - 4'd1;
                    div_d  = '0;
                    if (cnt_q != CNT_FULL)
                        cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_d == CNT_FULL)
                        state_d = DONE;
                    else if (left_d == 4'd0)
                        state_d = LOAD;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Head is loaded on the edge entering a strobe cycle so it is stable for the whole strobe
        // and held unchanged between strobes.
        if (state_d == SHIFT && div_d == DIV_LAST)
            head_d = byte_d[7];
    end

    assign ccff_head     = head_q;
    assign ccff_shift_en = strobe;
    assign cfg_done      = (state_q == DONE);
    assign err           = err_q;
    assign bit_count     = cnt_q;

endmodule

// File: tb/tb_config_chain_loader.sv
// Randomized bench for config_chain_loader against a schedule-based reference model
// (each accepted byte books eight timed strobes; the model replays that timeline).
module tb_config_chain_loader;

    localparam int LEN = 20;
    localparam int DIV = 3;
    localparam int CW  = $clog2(LEN + 1);

    logic          clk = 1'b0;
    logic          rst_n, start, abort, s_valid;
    logic [7:0]    s_data;
    logic          s_ready, ccff_head, ccff_shift_en, cfg_done, busy, err;
    logic [CW-1:0] bit_count;

    always #5 clk = ~clk;

    config_chain_loader #(.CHAIN_LEN(LEN), .SHIFT_DIV(DIV)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .ccff_head(ccff_head), .ccff_shift_en(ccff_shift_en),
        .cfg_done(cfg_done), .busy(busy), .err(err), .bit_count(bit_count)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    typedef struct { int at; bit b; } strobe_t;
    strobe_t sq[$];
    bit m_active, m_done, m_err;
    int m_count, m_ready_at;

    task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    endtask

    task automatic model_reset();
        m_active = 1'b0; m_done = 1'b0; m_err = 1'b0;
        m_count = 0; m_ready_at = 0; sq.delete();
    endtask

    // One clock cycle: drive, check at the falling edge, advance the model, cross the rising edge.
    task automatic step(input bit st, input bit ab, input bit sv, input logic [7:0] sd);
        bit exp_rdy, exp_stb;
        start = st; abort = ab; s_valid = sv; s_data = sd;
        @(negedge clk);
        exp_rdy = m_active && (cyc >= m_ready_at) && !ab;
        exp_stb = m_active && (sq.size() > 0) && (sq[0].at == cyc) && !ab;
        check("s_ready", s_ready, exp_rdy);
        check("shift_en", ccff_shift_en, exp_stb);
        if (exp_stb) check("head", ccff_head, sq[0].b);
        check("busy", busy, m_active);
        check("cfg_done", cfg_done, m_done);
        check("err", err, m_err);
        check("bit_count", bit_count, m_count);

        if (m_active && ab) begin
            m_active = 1'b0; m_err = 1'b1; sq.delete();
        end else if (m_active) begin
            if (exp_stb) begin
                void'(sq.pop_front());
                m_count++;
                if (m_count == LEN) begin
                    m_active = 1'b0; m_done = 1'b1; sq.delete();
                end
            end
            if (exp_rdy && sv) begin
                for (int k = 1; k <= 8; k++) sq.push_back('{cyc + k * DIV, sd[8 - k]});
                m_ready_at = cyc + 8 * DIV + 1;
            end
        end else if (st) begin
            m_active = 1'b1; m_done = 1'b0; m_err = 1'b0;
            m_count = 0; m_ready_at = cyc + 1;
        end
        @(posedge clk); #1;
        cyc++;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"}, s_ready, 0);
        check({tag, "_head"}, ccff_head, 0);
        check({tag, "_shift"}, ccff_shift_en, 0);
        check({tag, "_done"}, cfg_done, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_count"}, bit_count, 0);
    endtask

    initial begin
        int guard;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; s_valid = 1'b0; s_data = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;

        // Idle cycles: abort and valid must be ignored outside a load.
        repeat (4) step(1'b0, 1'b1, 1'b1, 8'hFF);

        // Load stalls with no valid data, then a full load held valid through DONE.
        step(1'b1, 1'b0, 1'b0, 8'h00);
        repeat (5) step(1'b0, 1'b0, 1'b0, 8'h00);
        guard = 0;
        while (!m_done && guard < 200) begin
            step(1'b0, 1'b0, 1'b1, 8'($urandom));
            guard++;
        end
        check("load_timeout", guard < 200, 1);
        repeat (4) step(1'b0, 1'b0, 1'b1, 8'hC0);
        check("done_count", bit_count, LEN);

        // Abort right after the 5th strobe; then a fresh start clears err and count.
        step(1'b1, 1'b0, 1'b0, 8'h00);
        guard = 0;
        while (m_count < 5 && guard < 200) begin
            step(1'b0, 1'b0, 1'b1, 8'hA5);
            guard++;
        end
        check("abort_timeout", guard < 200, 1);
        step(1'b0, 1'b1, 1'b1, 8'h3C);
        check("abort_count", bit_count, 5);
        check("abort_err", err, 1);
        repeat (2 * DIV) step(1'b0, 1'b0, 1'b1, 8'h3C);
        step(1'b1, 1'b0, 1'b0, 8'h00);
        check("restart_err", err, 0);
        check("restart_count", bit_count, 0);

        // Random traffic, including starts while busy and occasional aborts.
        for (int i = 0; i < 2500; i++) begin
            bit st;
            st = m_active ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 3) == 0);
            step(st, $urandom_range(0, 199) == 0, $urandom_range(0, 9) < 6, 8'($urandom));
        end

        // Asynchronous reset between edges while shifting.
        if (!m_active) step(1'b1, 1'b0, 1'b0, 8'h00);
        guard = 0;
        while (sq.size() == 0 && guard < 200) begin
            step(1'b0, 1'b0, 1'b1, 8'hFF);
            guard++;
        end
        check("arst_timeout", guard < 200, 1);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        #2 rst_n = 1'b0;
        #1 check_all_zero("arst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        repeat (6) step(1'b0, 1'b0, 1'b1, 8'hFF);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
